// File: rtl/pipes_diffsquare_ctrl.sv
// Serial front/back end for the diff-square pipe bank: packs operand pairs into
// lane vectors, pulses EN once the lanes have settled, then streams the results out.
module pipes_diffsquare_ctrl #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned SETTLE = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_a,
  input  logic [31:0]           in_b,
  output logic [32*WIDTH-1:0]   vals0,
  output logic [32*WIDTH-1:0]   vals1,
  output logic                  EN,
  input  logic [32*WIDTH-1:0]   pipeout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_SETTLE,
    S_FIRE,
    S_CAPTURE,
    S_SEND
  } state_t;

  state_t              state, state_next;
  logic [IW-1:0]       idx, idx_next;
  logic [CW-1:0]       cnt, cnt_next;
  logic [32*WIDTH-1:0] result;

  always_comb begin
    state_next = state;
    idx_next   = idx;
    cnt_next   = cnt;
    unique case (state)
      S_LOAD: begin
        if (in_valid) begin
          if (idx == LAST_IDX) begin
            idx_next   = '0;
            state_next = S_SETTLE;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      S_SETTLE: begin
        if (cnt == LAST_CNT) begin
          cnt_next   = '0;
          state_next = S_FIRE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      S_FIRE:    state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_SEND;
      S_SEND: begin
        if (out_ready) begin
          if (idx == LAST_IDX) begin
            idx_next   = '0;
            state_next = S_LOAD;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      default:   state_next = S_LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_LOAD);
    busy      = (state != S_LOAD);
    out_valid = (state == S_SEND);
    out_data  = out_valid ? result[32*idx +: 32] : '0;
    out_last  = out_valid && (idx == LAST_IDX);
  end

  // EN is registered from FIRE, so it is high exactly during CAPTURE and falls
  // on the same edge that samples pipeout.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= S_LOAD;
      idx    <= '0;
      cnt    <= '0;
      EN     <= 1'b0;
      vals0  <= '0;
      vals1  <= '0;
      result <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      cnt   <= cnt_next;
      EN    <= (state == S_FIRE);
      if (state == S_LOAD && in_valid) begin
        vals0[32*idx +: 32] <= in_a;
        vals1[32*idx +: 32] <= in_b;
      end
      if (state == S_CAPTURE) begin
        result <= pipeout;
      end
    end
  end

endmodule

// File: tb/tb_pipes_diffsquare_ctrl.sv
// Directed bench for pipes_diffsquare_ctrl (WIDTH=4, SETTLE=2) with a stand-in
// bank that returns hand-known float32 patterns while EN is high.
module tb_pipes_diffsquare_ctrl;

  localparam int W = 4;

  logic           CLK = 1'b0;
  logic           RST_N = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [31:0]    in_a = '0;
  logic [31:0]    in_b = '0;
  logic [32*W-1:0] vals0, vals1, pipeout;
  logic           EN;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [31:0]    out_data;
  logic           out_last;
  logic           busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int en_hi = 0;
  int en_rise = -1;
  logic en_prev = 1'b0;
  logic bb = 1'b0;

  pipes_diffsquare_ctrl #(.WIDTH(W), .SETTLE(2)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .vals0(vals0), .vals1(vals1), .EN(EN), .pipeout(pipeout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Stand-in bank: diff 5 -> 25.0, diff 3 -> 9.0, otherwise a lane-identifying tag.
  function automatic logic [31:0] bank_f(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    if (d == 32'd5) return 32'h41C8_0000;
    if (d == 32'd3) return 32'h4110_0000;
    return {a[15:0], b[15:0]};
  endfunction

  always_comb begin
    pipeout = '0;
    for (int i = 0; i < W; i++)
      if (EN) pipeout[32*i +: 32] = bank_f(vals0[32*i +: 32], vals1[32*i +: 32]);
  end

  always @(negedge CLK) begin
    if (!RST_N) begin
      en_prev <= 1'b0;
    end else begin
      en_prev <= EN;
      if (EN) en_hi <= en_hi + 1;
      if (EN && !en_prev) en_rise <= cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic feed(input int aoff, input int gap, output int e0);
    int guard;
    for (int i = 0; i < W; i++) begin
      in_valid = 1'b1;
      in_a = 32'(i + aoff);
      in_b = 32'(i);
      guard = 0;
      while (!in_ready && guard < 60) begin
        step();
        guard++;
      end
      check("in_wait", 64'(guard < 60), 64'd1);
      step();
      if (i == 1 && gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) step();
      end
    end
    in_valid = 1'b0;
    e0 = cyc;
  endtask

  task automatic drain(input logic [31:0] base, input logic [31:0] stepv, input int e0,
                       input int stall_lane, input int nstall, input int nlanes);
    int guard;
    logic [31:0] hold;
    out_ready = 1'b1;
    guard = 0;
    while (!out_valid && guard < 40) begin
      if (bb) check("bb_ready_low", 64'(in_ready), 64'd0);
      step();
      guard++;
    end
    check("valid_wait", 64'(guard < 40), 64'd1);
    for (int k = 0; k < nlanes; k++) begin
      if (k == stall_lane) begin
        out_ready = 1'b0;
        hold = out_data;
        for (int j = 0; j < nstall; j++) begin
          step();
          check("bp_hold", 64'(out_data), 64'(hold));
          check("bp_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
      end
      check("out_data", 64'(out_data), 64'(base + stepv * 32'(k)));
      check("out_last", 64'(out_last), 64'(k == W - 1));
      if (stall_lane < 0) check("xfer_edge", 64'(cyc + 1), 64'(e0 + 5 + k));
      if (bb) check("bb_ready_low", 64'(in_ready), 64'd0);
      step();
    end
    if (nlanes == W) begin
      check("idle_valid", 64'(out_valid), 64'd0);
      check("idle_data", 64'(out_data), 64'd0);
    end
  endtask

  initial begin
    int e0;
    int en_base;

    // Reset held with in_valid asserted: nothing may be written.
    in_valid = 1'b1;
    in_a = 32'hDEAD_BEEF;
    in_b = 32'h1234_5678;
    #2 RST_N = 1'b0;
    #1;
    check("rst_ready_imm", 64'(in_ready), 64'd1);
    repeat (3) step();
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_en", 64'(EN), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_vals", 64'(vals0 == '0 && vals1 == '0), 64'd1);
    in_valid = 1'b0;
    RST_N = 1'b1;
    step();
    check("rel_ready", 64'(in_ready), 64'd1);
    check("rel_vals0", 64'(vals0 == '0), 64'd1);

    // Nominal batch: (i+5)-i -> 25.0 in every lane.
    en_base = en_hi;
    feed(5, 0, e0);
    check("busy_settle", 64'(busy), 64'd1);
    check("ready_settle", 64'(in_ready), 64'd0);
    drain(32'h41C8_0000, 32'd0, e0, -1, 0, W);
    check("en_rise", 64'(en_rise), 64'(e0 + 3));
    check("en_width", 64'(en_hi - en_base), 64'd1);

    // Input gap between lanes 1 and 2.
    en_base = en_hi;
    feed(5, 2, e0);
    check("gap_lane1", 64'(vals0[63:32]), 64'd6);
    check("gap_lane3", 64'(vals0[127:96]), 64'd8);
    drain(32'h41C8_0000, 32'd0, e0, -1, 0, W);
    check("gap_en_rise", 64'(en_rise), 64'(e0 + 3));
    check("gap_en_width", 64'(en_hi - en_base), 64'd1);

    // Backpressure on lane 2 with lane-distinct results.
    for (int i = 0; i < W; i++) begin
      in_valid = 1'b1;
      in_a = 32'h10 + 32'(i);
      in_b = 32'h20 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    e0 = cyc;
    drain(32'h0010_0020, 32'h0001_0001, e0, 2, 3, W);

    // Reset in SEND after lane 1 has transferred.
    feed(5, 0, e0);
    drain(32'h41C8_0000, 32'd0, e0, -1, 0, 2);
    #2 RST_N = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_en", 64'(EN), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    check("mid_rst_vals", 64'(vals0 == '0), 64'd1);
    #3 RST_N = 1'b1;
    step();
    feed(3, 0, e0);
    drain(32'h4110_0000, 32'd0, e0, -1, 0, W);

    // Back-to-back with in_valid held high.
    feed(5, 0, e0);
    in_valid = 1'b1;
    in_a = 32'd3;
    in_b = 32'd0;
    bb = 1'b1;
    drain(32'h41C8_0000, 32'd0, e0, -1, 0, W);
    bb = 1'b0;
    check("bb_first_load", 64'(in_ready), 64'd1);
    step();
    check("bb_lane0", 64'(vals0[31:0]), 64'd3);
    for (int i = 1; i < W; i++) begin
      in_a = 32'(i + 3);
      in_b = 32'(i);
      step();
    end
    in_valid = 1'b0;
    e0 = cyc;
    drain(32'h4110_0000, 32'd0, e0, -1, 0, W);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
